// File: rtl/cdc_hs_rx_fifo_if.sv
// Bundle between the req/ack sender, the receive FIFO and its consumer.
// The master modport is the environment side (sender plus consumer).
interface cdc_hs_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic              req_async;
  logic [DATA_W-1:0] data_async;
  logic              ack;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LVL_W-1:0]  level;
  logic [CNT_W-1:0]  xfer_cnt;

  modport master (
    output req_async, data_async, out_ready,
    input  ack, out_valid, out_data, level, xfer_cnt
  );

  modport slave (
    input  req_async, data_async, out_ready,
    output ack, out_valid, out_data, level, xfer_cnt
  );
endinterface

// File: rtl/cdc_hs_rx_fifo.sv
// Receive side of a multi-bit req/ack CDC handshake feeding a small FIFO.
// Supports 4-phase (MODE=0) and 2-phase toggle (MODE=1) protocols.
module cdc_hs_rx_fifo #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int MODE        = 0,
  parameter int DEPTH       = 4,
  parameter int CNT_W       = 16
) (
  input logic              clk_rx,
  input logic              rst_n,
  cdc_hs_rx_fifo_if.slave  hs
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_s;
  logic                   ack_q;
  logic                   pending;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   release_ack;
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          level_q;
  logic [CNT_W-1:0]       xfer_q;
  logic [DATA_W-1:0]      mem [DEPTH];

  always_ff @(posedge clk_rx or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], hs.req_async};
  end

  assign req_s = sync_q[SYNC_STAGES-1];

  // Full is judged on the registered level, so a same-cycle pop never makes room for a push.
  assign full        = (level_q == FULL_LVL);
  assign empty       = (level_q == '0);
  assign pending     = (MODE == 0) ? (req_s & ~ack_q) : (req_s ^ ack_q);
  assign push        = pending & ~full;
  assign pop         = ~empty & hs.out_ready;
  assign release_ack = (MODE == 0) & ~req_s & ack_q;

  always_ff @(posedge clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
    end else if (push) begin
      ack_q <= (MODE == 0) ? 1'b1 : ~ack_q;
    end else if (release_ack) begin
      ack_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_rx or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
      xfer_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        xfer_q <= xfer_q + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage is not reset; entries are only observed through the valid pointers.
  always_ff @(posedge clk_rx) begin
    if (push) mem[wr_ptr] <= hs.data_async;
  end

  assign hs.ack       = ack_q;
  assign hs.out_valid = ~empty;
  assign hs.out_data  = mem[rd_ptr];
  assign hs.level     = level_q;
  assign hs.xfer_cnt  = xfer_q;
endmodule

// File: tb/tb_cdc_hs_rx_fifo.sv
// Scoreboard bench for cdc_hs_rx_fifo: one 4-phase and one 2-phase instance.
`timescale 1ns/1ps
module tb_cdc_hs_rx_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic clk_rx = 1'b0;
  logic clk_tx = 1'b0;
  logic rst_n  = 1'b0;

  always #3 clk_rx = ~clk_rx;
  always #7 clk_tx = ~clk_tx;

  cdc_hs_rx_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) hs0 ();
  cdc_hs_rx_fifo_if #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) hs1 ();

  cdc_hs_rx_fifo #(.DATA_W(DW), .SYNC_STAGES(2), .MODE(0), .DEPTH(DEPTH), .CNT_W(CW)) u_dut0 (
    .clk_rx(clk_rx), .rst_n(rst_n), .hs(hs0)
  );
  cdc_hs_rx_fifo #(.DATA_W(DW), .SYNC_STAGES(2), .MODE(1), .DEPTH(DEPTH), .CNT_W(CW)) u_dut1 (
    .clk_rx(clk_rx), .rst_n(rst_n), .hs(hs1)
  );

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  logic rdy0_val = 1'b0, rdy1_val = 1'b0, rnd_mode = 1'b0, rnd_rdy = 1'b0;
  logic ack_t1 = 1'b0, ack_t2 = 1'b0, ack1_prev = 1'b0;
  int   tog1 = 0;
  int   max_lvl = 0;
  int   n0 = 0;
  bit   abort = 1'b0;

  assign hs0.out_ready = rnd_mode ? rnd_rdy : rdy0_val;
  assign hs1.out_ready = rdy1_val;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_rx);
    #1;
  endtask

  task automatic wait_ack(input int which, input logic v);
    int n = 0;
    logic a;
    do begin
      cyc(1);
      n++;
      a = (which == 0) ? hs0.ack : hs1.ack;
    end while (a !== v && n < 20);
    if (a !== v) begin
      checks++;
      errors++;
      $display("FAIL ack%0d_wait got=%b required=%b", which, a, v);
    end
  endtask

  task automatic rx_req0(input logic [DW-1:0] d);
    hs0.data_async = d;
    hs0.req_async  = 1'b1;
    q0.push_back(d);
    n0++;
    wait_ack(0, 1'b1);
    hs0.req_async = 1'b0;
    wait_ack(0, 1'b0);
  endtask

  task automatic wait_tx(input logic v);
    int n = 0;
    while (ack_t2 !== v && n < 200) begin
      @(posedge clk_tx);
      #1;
      n++;
    end
    if (ack_t2 !== v) begin
      checks++;
      errors++;
      abort = 1'b1;
      $display("FAIL tx_ack_wait got=%b required=%b", ack_t2, v);
    end
  endtask

  task automatic tx_xfer0(input logic [DW-1:0] d);
    @(posedge clk_tx);
    #1;
    hs0.data_async = d;
    hs0.req_async  = 1'b1;
    q0.push_back(d);
    wait_tx(1'b1);
    hs0.req_async = 1'b0;
    wait_tx(1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(3);
    q0.delete();
    q1.delete();
    n0 = 0;
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic wait_drain0(input int budget);
    int n = 0;
    while ((q0.size() != 0 || hs0.level != 0) && n < budget) begin
      cyc(1);
      n++;
    end
    chk("drain0_left", 32'(q0.size()), 32'd0);
  endtask

  // Sender-domain view of ack through two sender flops.
  initial forever begin
    @(posedge clk_tx);
    ack_t2 = ack_t1;
    ack_t1 = hs0.ack;
  end

  initial forever begin
    @(posedge clk_rx);
    #1;
    rnd_rdy = 1'($urandom_range(0, 1));
  end

  // Monitors: a word leaves whenever out_valid & out_ready hold across an edge.
  initial forever begin
    @(negedge clk_rx);
    if (rst_n && hs0.out_valid && hs0.out_ready) begin
      if (q0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb0_extra got=%0h required=none", hs0.out_data);
      end else begin
        chk("sb0_data", 32'(hs0.out_data), 32'(q0.pop_front()));
      end
    end
    if (rst_n && int'(hs0.level) > max_lvl) max_lvl = int'(hs0.level);
  end

  initial forever begin
    @(negedge clk_rx);
    if (rst_n && hs1.out_valid && hs1.out_ready) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb1_extra got=%0h required=none", hs1.out_data);
      end else begin
        chk("sb1_data", 32'(hs1.out_data), 32'(q1.pop_front()));
      end
    end
    if (rst_n && hs1.ack !== ack1_prev) tog1++;
    ack1_prev = hs1.ack;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    hs0.req_async  = 1'b0;
    hs0.data_async = '0;
    hs1.req_async  = 1'b0;
    hs1.data_async = '0;
    do_reset();

    chk("rst_ack0",   32'(hs0.ack),       32'd0);
    chk("rst_valid0", 32'(hs0.out_valid), 32'd0);
    chk("rst_level0", 32'(hs0.level),     32'd0);
    chk("rst_xfer0",  32'(hs0.xfer_cnt),  32'd0);
    chk("rst_ack1",   32'(hs1.ack),       32'd0);
    chk("rst_valid1", 32'(hs1.out_valid), 32'd0);

    // 4-phase single transfer: latency and release timing
    rdy0_val = 1'b1;
    hs0.data_async = 8'hA5;
    hs0.req_async  = 1'b1;
    q0.push_back(8'hA5);
    n0++;
    cyc(2);
    chk("t1_ack_e1", 32'(hs0.ack), 32'd0);
    cyc(1);
    chk("t1_ack_e2",   32'(hs0.ack),       32'd1);
    chk("t1_valid_e2", 32'(hs0.out_valid), 32'd1);
    chk("t1_data_e2",  32'(hs0.out_data),  32'h0A5);
    chk("t1_xfer_e2",  32'(hs0.xfer_cnt),  32'd1);
    hs0.req_async = 1'b0;
    cyc(2);
    chk("t1_ack_f1", 32'(hs0.ack), 32'd1);
    cyc(1);
    chk("t1_ack_f2", 32'(hs0.ack), 32'd0);
    cyc(3);
    chk("t1_empty_level", 32'(hs0.level),     32'd0);
    chk("t1_empty_valid", 32'(hs0.out_valid), 32'd0);

    // Backpressure and full-with-pop
    rdy0_val = 1'b0;
    for (int i = 0; i < 4; i++) rx_req0(8'(10 + i));
    chk("t3_level_full", 32'(hs0.level), 32'd4);
    hs0.data_async = 8'd14;
    hs0.req_async  = 1'b1;
    q0.push_back(8'd14);
    n0++;
    cyc(8);
    chk("t3_ack_withheld", 32'(hs0.ack),      32'd0);
    chk("t3_level_stall",  32'(hs0.level),    32'd4);
    chk("t3_xfer_stall",   32'(hs0.xfer_cnt), 32'(n0 - 1));
    rdy0_val = 1'b1;
    cyc(1);
    chk("t4_level_pop",  32'(hs0.level),    32'd3);
    chk("t4_ack_nocap",  32'(hs0.ack),      32'd0);
    chk("t4_xfer_nocap", 32'(hs0.xfer_cnt), 32'(n0 - 1));
    rdy0_val = 1'b0;
    cyc(1);
    chk("t4_level_cap", 32'(hs0.level),    32'd4);
    chk("t4_ack_cap",   32'(hs0.ack),      32'd1);
    chk("t4_xfer_cap",  32'(hs0.xfer_cnt), 32'(n0));
    hs0.req_async = 1'b0;
    rdy0_val = 1'b1;
    wait_drain0(50);
    cyc(3);
    chk("t3_ack_released", 32'(hs0.ack), 32'd0);

    // 2-phase: six toggles carrying 1..6
    rdy1_val = 1'b1;
    tog1 = 0;
    for (int i = 1; i <= 6; i++) begin
      hs1.data_async = 8'(i);
      hs1.req_async  = ~hs1.req_async;
      q1.push_back(8'(i));
      wait_ack(1, hs1.req_async);
    end
    cyc(4);
    chk("t2_ack_eq_req", 32'(hs1.ack),      32'(hs1.req_async));
    chk("t2_xfer",       32'(hs1.xfer_cnt), 32'd6);
    chk("t2_toggles",    32'(tog1),         32'd6);
    chk("t2_sb_left",    32'(q1.size()),    32'd0);

    // Random consumer, sender on its own clock, 1000 transfers
    do_reset();
    max_lvl  = 0;
    rnd_mode = 1'b1;
    for (int i = 0; i < 1000 && !abort; i++) tx_xfer0(8'($urandom_range(0, 255)));
    wait_drain0(500);
    chk("t5_xfer",        32'(hs0.xfer_cnt),              32'd1000);
    chk("t5_level_bound", 32'(max_lvl <= DEPTH),          32'd1);
    chk("t5_level_end",   32'(hs0.level),                 32'd0);
    rnd_mode = 1'b0;
    rdy0_val = 1'b0;
    cyc(2);

    // Reset while stalled with level=3 and ack=1
    rx_req0(8'h21);
    rx_req0(8'h22);
    hs0.data_async = 8'h23;
    hs0.req_async  = 1'b1;
    q0.push_back(8'h23);
    wait_ack(0, 1'b1);
    chk("t6_level_pre", 32'(hs0.level), 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_ack_rst",   32'(hs0.ack),       32'd0);
    chk("t6_level_rst", 32'(hs0.level),     32'd0);
    chk("t6_valid_rst", 32'(hs0.out_valid), 32'd0);
    chk("t6_xfer_rst",  32'(hs0.xfer_cnt),  32'd0);
    hs0.req_async = 1'b0;
    q0.delete();
    cyc(3);
    rst_n = 1'b1;
    cyc(10);
    chk("t6_ack_idle",   32'(hs0.ack),       32'd0);
    chk("t6_level_idle", 32'(hs0.level),     32'd0);
    chk("t6_valid_idle", 32'(hs0.out_valid), 32'd0);
    chk("t6_xfer_idle",  32'(hs0.xfer_cnt),  32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdc_hs_rx_fifo.md
Name: cdc_hs_rx_fifo

Overview:
- Parametrised receive side of the multi-bit CDC req/ack handshake.
- Lives entirely in the receive clock domain. Synchronises an asynchronous request, captures the quasi-static data bus and returns ack.
- Buffers captured words in a small FIFO with a valid/ready output.
- Supports both 4-phase (level) and 2-phase (toggle) protocols. Applies backpressure to the sender by withholding ack while the FIFO is full.

Parameters:
- DATA_W, 8: width of the crossing data bus.
- SYNC_STAGES, 2: flops in the req synchroniser; legal range >= 2.
- MODE, 0: 0 = 4-phase level handshake; 1 = 2-phase toggle handshake.
- DEPTH, 4: FIFO entries; power of 2, >= 2.
- CNT_W, 16: width of the transfer counter.

Ports:
- clk_rx  input  1  receive-domain clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_async  input  1  request from sender domain; asynchronous; synchronised internally.
- data_async  input  DATA_W  sender data; guaranteed stable from req edge until ack edge is seen by sender.
- ack  output  1  acknowledge to sender domain; driven directly from a flop.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head word when high with out_valid.
- out_data  output  DATA_W  FIFO head word; valid only while out_valid=1.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- xfer_cnt  output  CNT_W  number of words captured since reset; wraps to 0 after all-ones.

Behaviour:
- Reset (rst_n=0, async): synchroniser flops, ack, FIFO pointers, level and xfer_cnt all go to 0. out_valid=0. out_data is don't-care.
- Synchroniser: req_s = last stage of a SYNC_STAGES-deep shift register fed from req_async. No other logic reads req_async.
- Pending event:
  - MODE=0: pending = req_s & ~ack.
  - MODE=1: pending = req_s ^ ack.
- Capture: on an edge where pending=1 and the FIFO is not full (level<DEPTH, registered value):
  - write data_async into the FIFO;
  - MODE=0: ack<=1; MODE=1: ack<=~ack;
  - xfer_cnt<=xfer_cnt+1.
- MODE=0 release: on an edge where req_s=0 and ack=1, ack<=0. No data movement.
- Full stall: pending=1 with level==DEPTH means no capture and ack holds. Capture occurs on the first edge where level<DEPTH.
- Full-with-pop: a pop in the same cycle does NOT free space for a same-cycle push. Full is evaluated on registered level.
- Latency: req_async is high at setup of edge E0. req_s rises after edge E(SYNC_STAGES-1). Capture happens at E(SYNC_STAGES). ack and out_valid (if FIFO was empty) are both visible after E(SYNC_STAGES).
- FIFO: out_data driven combinationally from the head entry. Pop when out_valid & out_ready.
- Simultaneous push and pop (not full, not empty): level unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- out_ready while empty: ignored; no underflow and level stays 0.
- Ordering: strict FIFO order and no loss or duplication under any out_ready pattern, given a protocol-compliant sender.
- MODE=0 back-to-back: the next capture requires req_s to fall, ack to drop, then req_s to rise again.
- Reset mid-operation: all state clears immediately, with no pending-write completion.
  - If req_async is still high after reset release in MODE=0, it is treated as a new request and captured again.
  - In MODE=1, req_async=1 after reset is treated as one pending event.
  - System-level rule: both domains are reset together.

Test Plan:
- MODE=0, SYNC_STAGES=2, out_ready=1. Raise req_async with data_async=8'hA5 just before E0 -> ack=1 and out_valid=1 after E2; out_data=8'hA5; xfer_cnt=1. Drop req -> ack=0 two edges after req_s falls is not allowed; it must be exactly the edge after req_s=0.
- MODE=1, 6 toggles carrying 1..6, out_ready=1 -> ack toggles 6 times; outputs 1,2,3,4,5,6 in order; final ack equals final req_async; xfer_cnt=6.
- Backpressure, DEPTH=4, out_ready=0, 5 requests carrying 10..14 -> level reaches 4; 5th ack withheld. Raise out_ready for one cycle -> pop 10; 14 captured on the following edge; level=4.
- Full with out_ready=1 and pending in the same cycle -> that edge: level 4->3, no capture; next edge: capture, level=4.
- Random out_ready (50%), 1000 MODE=0 transfers with random data and sender clock ratio 3:7 -> scoreboard matches exactly; level never exceeds DEPTH; xfer_cnt=1000.
- Assert rst_n mid-stall with level=3 and ack=1 -> immediately ack=0, level=0, out_valid=0, xfer_cnt=0. Release with req_async=0 -> idle, no capture.
